// File: rtl/pipe_pkg.sv
// pipe_pkg: control-bundle layout and NOP encoding shared by the bubble mux and pipeline registers
package pipe_pkg;
    localparam int ALUSRC_W   = 2;
    localparam int REGDST_W   = 2;
    localparam int ALUOP_W    = 3;
    localparam int MEMTOREG_W = 2;

    typedef struct packed {
        logic                  alualtsrc;
        logic [ALUSRC_W-1:0]   alusrc;
        logic [REGDST_W-1:0]   regdst;
        logic [ALUOP_W-1:0]    aluop;
        logic                  memwr;
        logic                  memrd;
        logic                  bbne;
        logic                  bbeq;
        logic                  bblez;
        logic                  bbgtz;
        logic                  jump;
        logic [MEMTOREG_W-1:0] memtoreg;
        logic                  regwr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear beats increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold, flush-to-NOP and a saturating bubble counter
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              bubble_clr,
    input  logic              id_alualtsrc,
    input  logic [1:0]        id_alusrc,
    input  logic [1:0]        id_regdst,
    input  logic [2:0]        id_aluop,
    input  logic              id_memwr,
    input  logic              id_memrd,
    input  logic              id_bbne,
    input  logic              id_bbeq,
    input  logic              id_bblez,
    input  logic              id_bbgtz,
    input  logic              id_jump,
    input  logic [1:0]        id_memtoreg,
    input  logic              id_regwr,
    input  logic [DATA_W-1:0] id_pcplus4,
    input  logic [DATA_W-1:0] id_rsdata,
    input  logic [DATA_W-1:0] id_rtdata,
    input  logic [DATA_W-1:0] id_signimm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_shamt,
    output logic              ex_alualtsrc,
    output logic [1:0]        ex_alusrc,
    output logic [1:0]        ex_regdst,
    output logic [2:0]        ex_aluop,
    output logic              ex_memwr,
    output logic              ex_memrd,
    output logic              ex_bbne,
    output logic              ex_bbeq,
    output logic              ex_bblez,
    output logic              ex_bbgtz,
    output logic              ex_jump,
    output logic [1:0]        ex_memtoreg,
    output logic              ex_regwr,
    output logic [DATA_W-1:0] ex_pcplus4,
    output logic [DATA_W-1:0] ex_rsdata,
    output logic [DATA_W-1:0] ex_rtdata,
    output logic [DATA_W-1:0] ex_signimm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_shamt,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  bubble_cnt
);
    ctrl_t id_c, ex_c;

    assign id_c = '{alualtsrc: id_alualtsrc, alusrc: id_alusrc, regdst: id_regdst, aluop: id_aluop,
                    memwr: id_memwr, memrd: id_memrd, bbne: id_bbne, bbeq: id_bbeq, bblez: id_bblez,
                    bbgtz: id_bbgtz, jump: id_jump, memtoreg: id_memtoreg, regwr: id_regwr};

    assign {ex_alualtsrc, ex_alusrc, ex_regdst, ex_aluop, ex_memwr, ex_memrd, ex_bbne, ex_bbeq,
            ex_bblez, ex_bbgtz, ex_jump, ex_memtoreg, ex_regwr} = ex_c;

    always_ff @(posedge clk or posedge rst)
        if (rst || flush) begin
            ex_c       <= CTRL_NOP;
            ex_pcplus4 <= '0;
            ex_rsdata  <= '0;
            ex_rtdata  <= '0;
            ex_signimm <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_shamt   <= '0;
            ex_valid   <= 1'b0;
        end else if (!stall) begin
            ex_c       <= id_c;
            ex_pcplus4 <= id_pcplus4;
            ex_rsdata  <= id_rsdata;
            ex_rtdata  <= id_rtdata;
            ex_signimm <= id_signimm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_shamt   <= id_shamt;
            ex_valid   <= id_valid;
        end

    // a held bubble during stall is not a new one
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(flush || (!stall && !id_valid)),
        .clr(bubble_clr),
        .cnt(bubble_cnt)
    );
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg built with a 4-bit bubble counter
module tb_id_ex_reg;
    import pipe_pkg::*;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pcplus4, rsdata, rtdata, signimm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        valid;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 0, rst = 1, stall = 0, flush = 0, id_valid = 0, bubble_clr = 0;
    ctrl_t id_ctrl = '0;
    logic [31:0] id_pcplus4 = 0, id_rsdata = 0, id_rtdata = 0, id_signimm = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, id_shamt = 0;

    logic ex_alualtsrc, ex_memwr, ex_memrd, ex_bbne, ex_bbeq, ex_bblez, ex_bbgtz, ex_jump, ex_regwr, ex_valid;
    logic [1:0] ex_alusrc, ex_regdst, ex_memtoreg;
    logic [2:0] ex_aluop;
    logic [31:0] ex_pcplus4, ex_rsdata, ex_rtdata, ex_signimm;
    logic [4:0] ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [3:0] bubble_cnt;

    exp_t obs, m, e;
    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    assign obs = {ex_alualtsrc, ex_alusrc, ex_regdst, ex_aluop, ex_memwr, ex_memrd, ex_bbne, ex_bbeq,
                  ex_bblez, ex_bbgtz, ex_jump, ex_memtoreg, ex_regwr, ex_pcplus4, ex_rsdata, ex_rtdata,
                  ex_signimm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_valid, bubble_cnt};

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid), .bubble_clr(bubble_clr),
        .id_alualtsrc(id_ctrl.alualtsrc), .id_alusrc(id_ctrl.alusrc), .id_regdst(id_ctrl.regdst),
        .id_aluop(id_ctrl.aluop), .id_memwr(id_ctrl.memwr), .id_memrd(id_ctrl.memrd),
        .id_bbne(id_ctrl.bbne), .id_bbeq(id_ctrl.bbeq), .id_bblez(id_ctrl.bblez), .id_bbgtz(id_ctrl.bbgtz),
        .id_jump(id_ctrl.jump), .id_memtoreg(id_ctrl.memtoreg), .id_regwr(id_ctrl.regwr),
        .id_pcplus4(id_pcplus4), .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_signimm(id_signimm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_alualtsrc(ex_alualtsrc), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
        .ex_memwr(ex_memwr), .ex_memrd(ex_memrd), .ex_bbne(ex_bbne), .ex_bbeq(ex_bbeq),
        .ex_bblez(ex_bblez), .ex_bbgtz(ex_bbgtz), .ex_jump(ex_jump), .ex_memtoreg(ex_memtoreg),
        .ex_regwr(ex_regwr), .ex_pcplus4(ex_pcplus4), .ex_rsdata(ex_rsdata), .ex_rtdata(ex_rtdata),
        .ex_signimm(ex_signimm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    task automatic rand_id();
        logic [31:0] r;
        r = $urandom;
        id_ctrl = r[17:0];
        id_rs = r[22:18];
        id_rt = r[27:23];
        r = $urandom;
        id_rd = r[4:0];
        id_shamt = r[9:5];
        id_pcplus4 = $urandom;
        id_rsdata = $urandom;
        id_rtdata = $urandom;
        id_signimm = $urandom;
    endtask

    // predict the next EX contents from the current inputs, queue it, then advance one clock
    task automatic tick();
        exp_t n;
        n = m;
        if (flush) begin
            n = '0;
            n.cnt = m.cnt;
        end else if (!stall) begin
            n = {id_ctrl, id_pcplus4, id_rsdata, id_rtdata, id_signimm, id_rs, id_rt, id_rd, id_shamt,
                 id_valid, m.cnt};
        end
        if (bubble_clr) n.cnt = 0;
        else if ((flush || (!stall && !id_valid)) && m.cnt != 4'hF) n.cnt = m.cnt + 1;
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_init obs=%h exp=0", obs); end
        @(posedge clk); #1;
        rst = 0;
        m = '0;
        id_valid = 1;
        id_ctrl.aluop = 3'b101;
        id_ctrl.regwr = 1;
        id_pcplus4 = 32'h40;
        tick();
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL reset_preload obs=%h exp=%h", obs, e); end
        vectors++;
        if (ex_aluop !== 3'b101 || ex_regwr !== 1'b1 || ex_pcplus4 !== 32'h40) begin
            miscompares++;
            $display("FAIL reset_preload_fields aluop=%b regwr=%b pc=%h exp 101 1 00000040", ex_aluop, ex_regwr, ex_pcplus4);
        end
        #2 rst = 1;
        #1;
        m = '0;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_async obs=%h exp=0", obs); end
        flush = 0;
        id_valid = 0;
        @(posedge clk); #1;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_held obs=%h exp=0", obs); end
        rst = 0;
    endtask

    task automatic test_load();
        rand_id();
        id_valid = 1;
        id_rsdata = 32'hDEAD_BEEF;
        id_rd = 5'd9;
        id_ctrl.memtoreg = 2'b01;
        tick();
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL load obs=%h exp=%h", obs, e); end
        vectors++;
        if (ex_rsdata !== 32'hDEAD_BEEF || ex_rd !== 5'd9 || ex_memtoreg !== 2'b01 || ex_valid !== 1'b1 || bubble_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL load_fields rs=%h rd=%0d mtr=%b v=%b cnt=%0d exp deadbeef 9 01 1 0",
                     ex_rsdata, ex_rd, ex_memtoreg, ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_stall();
        stall = 1;
        id_valid = 0;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL stall%0d obs=%h exp=%h", i, obs, e); end
        end
        vectors++;
        if (ex_rsdata !== 32'hDEAD_BEEF || ex_valid !== 1'b1 || bubble_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL stall_frozen rs=%h v=%b cnt=%0d exp deadbeef 1 0", ex_rsdata, ex_valid, bubble_cnt);
        end
        stall = 0;
    endtask

    task automatic test_bubble();
        id_valid = 0;
        for (int i = 0; i < 2; i++) begin
            rand_id();
            tick();
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL bubble%0d obs=%h exp=%h", i, obs, e); end
        end
        vectors++;
        if (bubble_cnt !== 4'd2 || ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_count cnt=%0d v=%b exp 2 0", bubble_cnt, ex_valid);
        end
    endtask

    task automatic test_flush_stall();
        rand_id();
        id_valid = 1;
        tick();
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL preflush obs=%h exp=%h", obs, e); end
        rand_id();
        id_ctrl.regwr = 1;
        flush = 1;
        stall = 1;
        tick();
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL flush_stall obs=%h exp=%h", obs, e); end
        vectors++;
        if (ex_regwr !== 1'b0 || ex_valid !== 1'b0 || ex_rsdata !== 0 || ex_pcplus4 !== 0 || bubble_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL flush_fields regwr=%b v=%b rs=%h pc=%h cnt=%0d exp 0 0 0 0 3",
                     ex_regwr, ex_valid, ex_rsdata, ex_pcplus4, bubble_cnt);
        end
        flush = 0;
        stall = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            rand_id();
            id_valid = $urandom_range(0, 3) != 0;
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 5) == 0;
            bubble_clr = $urandom_range(0, 9) == 0;
            tick();
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL b2b%0d obs=%h exp=%h", i, obs, e); end
        end
        stall = 0;
        flush = 0;
        bubble_clr = 0;
    endtask

    task automatic test_saturation();
        bubble_clr = 1;
        tick();
        e = sb.pop_front();
        vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL sat_preclear obs=%h exp=%h", obs, e); end
        bubble_clr = 0;
        flush = 1;
        for (int i = 0; i < 20; i++) begin
            rand_id();
            tick();
            e = sb.pop_front();
            vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL sat%0d obs=%h exp=%h", i, obs, e); end
        end
        vectors++;
        if (bubble_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_value cnt=%0d exp 15", bubble_cnt); end
        bubble_clr = 1;
        tick();
        e = sb.pop_front();
        vectors++;
        if (bubble_cnt !== 4'd0 || obs !== e) begin
            miscompares++;
            $display("FAIL clr_over_flush cnt=%0d obs=%h exp=%h", bubble_cnt, obs, e);
        end
        bubble_clr = 0;
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_flush_stall();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
